// File: rtl/hazard_fwd_unit.sv
// Load-use / RAW hazard detection and EX operand forwarding for a 5-stage pipe; HAZARD_FORWARD_EN selects forwarding, else full interlock.
// Latency: stall/bubble_ex/forwardA/B combinational from tracked records; stall holds the front end, flush overrides it.
module hazard_fwd_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic [2:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        flush,
  output logic [1:0]  forwardA,
  output logic [1:0]  forwardB,
  output logic        stall,
  output logic        bubble_ex,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [2:0] rs;
    logic       rs_used;
    logic [2:0] rt;
    logic       rt_used;
    logic [2:0] rd;
    logic       reg_write;
    logic       mem_read;
  } rec_t;

  rec_t id_rec, ex_q, mem_q, wb_q;
  logic hazard;
  logic unused_bits;

  always_comb begin
    id_rec           = '0;
    id_rec.valid     = id_valid;
    id_rec.rs        = id_rs;
    id_rec.rs_used   = id_rs_used;
    id_rec.rt        = id_rt;
    id_rec.rt_used   = id_rt_used;
    id_rec.rd        = id_rd;
    id_rec.reg_write = id_reg_write;
    id_rec.mem_read  = id_mem_read;
  end

  // True when the ID instruction reads a register that producer p will write.
  function automatic logic src_hit(input rec_t p, input logic [2:0] rs, input logic rs_used,
                                   input logic [2:0] rt, input logic rt_used);
    return p.valid & p.reg_write & ((rs_used & (rs == p.rd)) | (rt_used & (rt == p.rd)));
  endfunction

`ifdef HAZARD_FORWARD_EN
  function automatic logic [1:0] fwd_sel(input rec_t e, input logic used, input logic [2:0] r,
                                         input rec_t m, input rec_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (e.valid && used && m.valid && m.reg_write && !m.mem_read && (r == m.rd))
      sel = 2'b10;
    else if (e.valid && used && w.valid && w.reg_write && (r == w.rd))
      sel = 2'b01;
    return sel;
  endfunction

  // Only a load sitting in EX cannot be forwarded in time.
  assign hazard   = id_valid & ex_q.mem_read & src_hit(ex_q, id_rs, id_rs_used, id_rt, id_rt_used);
  assign forwardA = fwd_sel(ex_q, ex_q.rs_used, ex_q.rs, mem_q, wb_q);
  assign forwardB = fwd_sel(ex_q, ex_q.rt_used, ex_q.rt, mem_q, wb_q);
`else
  // No bypass paths: wait until the producer has retired from WB.
  assign hazard   = id_valid & (src_hit(ex_q,  id_rs, id_rs_used, id_rt, id_rt_used) |
                                src_hit(mem_q, id_rs, id_rs_used, id_rt, id_rt_used) |
                                src_hit(wb_q,  id_rs, id_rs_used, id_rt, id_rt_used));
  assign forwardA = 2'b00;
  assign forwardB = 2'b00;
`endif

  assign stall     = hazard & ~flush;
  assign bubble_ex = rst_n & (stall | flush);

  // Record fields not consulted in every build configuration.
  assign unused_bits = ^{ex_q, mem_q, wb_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= (stall || flush) ? '0 : id_rec;
      mem_q <= flush ? '0 : ex_q;
      wb_q  <= mem_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (stall && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end

endmodule
